// File: rtl/ctrl_cruzamento.sv
// Phase sequencer for a two-street crossing with a shared pedestrian phase.
// Durations are host-programmable and take effect at the next state entry.
module ctrl_cruzamento #(
    parameter int W = 8,
    parameter logic [W-1:0] VERDE_DEF    = 8'd3,
    parameter logic [W-1:0] AMARELO_DEF  = 8'd3,
    parameter logic [W-1:0] VERMELHO_DEF = 8'd1,
    parameter logic [W-1:0] PED_DEF      = 8'd4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         bt,
    input  logic         cfg_we,
    input  logic [1:0]   cfg_sel,
    input  logic [W-1:0] cfg_val,
    output logic [2:0]   A,
    output logic [2:0]   B,
    output logic         P,
    output logic         pend,
    output logic [2:0]   fase
);

    typedef enum logic [2:0] {
        S_AV  = 3'd0,
        S_AA  = 3'd1,
        S_R1  = 3'd2,
        S_BV  = 3'd3,
        S_BA  = 3'd4,
        S_R2  = 3'd5,
        S_PED = 3'd6
    } state_t;

    state_t       st;
    state_t       nx;
    logic [W-1:0] cnt;
    logic [W-1:0] dv, da, dr, dp;
    logic [W-1:0] nlen;
    logic         ret;
    logic         z;
    logic         reload;
    logic         ped_in;

    // a programmed 0 behaves as a one-cycle phase
    function automatic logic [W-1:0] ld(input logic [W-1:0] d);
        return (d == '0) ? '0 : d - 1'b1;
    endfunction

    function automatic logic [2:0] luz_a(input state_t s);
        case (s)
            S_AV:    return 3'b001;
            S_AA:    return 3'b010;
            default: return 3'b100;
        endcase
    endfunction

    function automatic logic [2:0] luz_b(input state_t s);
        case (s)
            S_BV:    return 3'b001;
            S_BA:    return 3'b010;
            default: return 3'b100;
        endcase
    endfunction

    assign z = (cnt == '0);

    always_comb begin
        nx = st;
        case (st)
            S_AV:    if (z) nx = S_AA;
            S_AA:    if (z) nx = S_R1;
            S_R1:    if (z) nx = pend ? S_PED : S_BV;
            S_BV:    if (z) nx = S_BA;
            S_BA:    if (z) nx = S_R2;
            S_R2:    if (z) nx = pend ? S_PED : S_AV;
            S_PED:   if (z) nx = ret ? S_AV : S_BV;
            default: nx = S_AV;
        endcase
    end

    always_comb begin
        nlen = dp;
        case (nx)
            S_AV, S_BV: nlen = dv;
            S_AA, S_BA: nlen = da;
            S_R1, S_R2: nlen = dr;
            default:    nlen = dp;
        endcase
    end

    assign reload = (nx != st) || (st > S_PED);
    assign ped_in = (nx == S_PED) && (st != S_PED);

    always_ff @(posedge clk) begin
        if (rst) begin
            st   <= S_AV;
            cnt  <= ld(VERDE_DEF);
            dv   <= VERDE_DEF;
            da   <= AMARELO_DEF;
            dr   <= VERMELHO_DEF;
            dp   <= PED_DEF;
            ret  <= 1'b0;
            pend <= 1'b0;
            A    <= 3'b001;
            B    <= 3'b100;
            P    <= 1'b0;
            fase <= 3'd0;
        end else begin
            st  <= nx;
            cnt <= reload ? ld(nlen) : cnt - 1'b1;
            if (cfg_we) begin
                case (cfg_sel)
                    2'd0:    dv <= cfg_val;
                    2'd1:    da <= cfg_val;
                    2'd2:    dr <= cfg_val;
                    default: dp <= cfg_val;
                endcase
            end
            // entering the walk phase consumes the request, even a fresh press
            if (ped_in) begin
                pend <= 1'b0;
                ret  <= (st == S_R2);
            end else if (bt && st != S_PED) begin
                pend <= 1'b1;
            end
            A    <= luz_a(nx);
            B    <= luz_b(nx);
            P    <= (nx == S_PED);
            fase <= nx;
        end
    end

endmodule
